// File: rtl/icu_biu_refill_if.sv
// Refill port bundle: ICU miss request / beat return plus the 32-bit pipelined memory read port.
// The master side is the refill engine; the slave side is the ICU and memory around it.
interface icu_biu_refill_if;
    logic        icu_biu_req;
    logic [31:3] icu_biu_addr;
    logic        biu_icu_ack;
    logic        biu_icu_data_valid;
    logic [63:0] biu_icu_data;
    logic        biu_icu_data_last;
    logic        mem_req;
    logic [31:2] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  icu_biu_req,
        input  icu_biu_addr,
        output biu_icu_ack,
        output biu_icu_data_valid,
        output biu_icu_data,
        output biu_icu_data_last,
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        output icu_biu_req,
        output icu_biu_addr,
        input  biu_icu_ack,
        input  biu_icu_data_valid,
        input  biu_icu_data,
        input  biu_icu_data_last,
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/icu_biu_refill.sv
// I-cache line refill engine: fetches 8 words of a 32-byte line over an in-order read port
// and returns them to the ICU as four 64-bit beats, lower-addressed word in the low half.
module icu_biu_refill #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic             clk,
    input  logic             resetn,
    icu_biu_refill_if.master bus
);
    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    localparam logic [2:0] OutstLimit = 3'(MAX_OUTST);

    state_e      state_q;
    logic [26:0] line_q;
    logic [3:0]  iss_q;
    logic [2:0]  outst_q;
    logic [2:0]  rsp_q;
    logic [31:0] low_q;
    logic        ack_q;
    logic        valid_q;
    logic        last_q;
    logic [63:0] data_q;

    logic mem_req;
    logic grant;
    logic rvalid;
    logic unused_addr_bits;

    // Issue window is throttled by the registered outstanding count only.
    assign mem_req = (state_q == StFetch) && (iss_q < 4'd8) && (outst_q < OutstLimit);
    assign grant   = mem_req && bus.mem_gnt;
    // Responses outside an active fetch are protocol errors and are dropped.
    assign rvalid  = (state_q == StFetch) && !last_q && bus.mem_rvalid;

    assign bus.mem_req            = mem_req;
    assign bus.mem_addr           = {line_q, iss_q[2:0]};
    assign bus.biu_icu_ack        = ack_q;
    assign bus.biu_icu_data_valid = valid_q;
    assign bus.biu_icu_data       = data_q;
    assign bus.biu_icu_data_last  = last_q;

    assign unused_addr_bits = ^bus.icu_biu_addr[4:3];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            line_q  <= '0;
            iss_q   <= '0;
            outst_q <= '0;
            rsp_q   <= '0;
            low_q   <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.icu_biu_req) begin
                        line_q  <= bus.icu_biu_addr[31:5];
                        iss_q   <= '0;
                        outst_q <= '0;
                        rsp_q   <= '0;
                        ack_q   <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    // Leave one cycle after the last beat so the next ack trails it by two.
                    if (last_q) begin
                        state_q <= StIdle;
                    end
                    if (grant) begin
                        iss_q <= iss_q + 4'd1;
                    end
                    outst_q <= outst_q + {2'b00, grant} - {2'b00, rvalid};
                    if (rvalid) begin
                        rsp_q <= rsp_q + 3'd1;
                        if (!rsp_q[0]) begin
                            low_q <= bus.mem_rdata;
                        end else begin
                            data_q  <= {bus.mem_rdata, low_q};
                            valid_q <= 1'b1;
                            if (rsp_q == 3'd7) begin
                                last_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    a_outst_bound: assert property (@(posedge clk) disable iff (!resetn)
        outst_q <= OutstLimit);

    a_addr_hold: assert property (@(posedge clk) disable iff (!resetn)
        (bus.mem_req && !bus.mem_gnt) |=> (bus.mem_req && $stable(bus.mem_addr)));
endmodule

// File: tb/tb_icu_biu_refill.sv
// Bench for icu_biu_refill: two instances (MAX_OUTST 2 and 1) each with a scripted memory model;
// beats are checked against a queue of expected {last, data} filled when each request is driven.
module tb_icu_biu_refill;
    typedef struct {
        int          g;
        logic [28:0] addr;
        int          lat;
        bit          stall;
        bit          gap;
        int          first_k;
        int          last_k;
        int          spacing;
    } vec_t;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    logic [1:0]       req = '0;
    logic [1:0][28:0] req_addr = '0;
    int               lat [2] = '{1, 1};
    bit               stall_on [2] = '{1'b0, 1'b0};
    bit               gap_on [2] = '{1'b0, 1'b0};

    logic [1:0]       ack_s, dv_s, last_s, mreq_s, mgnt_s, rv_s;
    logic [1:0][63:0] data_s;
    logic [1:0][29:0] maddr_s;

    logic [64:0] exp_q0 [$];
    logic [64:0] exp_q1 [$];

    int          ob_acks, ob_ack_k, ob_last_k, ob_beats, ob_pair_err, ob_max_inf;
    int          ob_bk [4];
    logic [29:0] ob_addr0;
    logic        ob_req0;

    vec_t vecs [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        icu_biu_refill_if bus ();

        logic [31:0] rq_data [$];
        int          rq_due [$];
        int          gap;
        int          stall_seen;
        logic        rv;
        logic [31:0] rd;

        assign bus.icu_biu_req  = req[g];
        assign bus.icu_biu_addr = req_addr[g];
        assign bus.mem_gnt      = !(stall_on[g] && bus.mem_req && bus.mem_addr[4:2] == 3'd2
                                    && stall_seen < 3);
        assign bus.mem_rvalid   = rv;
        assign bus.mem_rdata    = rd;

        assign ack_s[g]   = bus.biu_icu_ack;
        assign dv_s[g]    = bus.biu_icu_data_valid;
        assign last_s[g]  = bus.biu_icu_data_last;
        assign data_s[g]  = bus.biu_icu_data;
        assign mreq_s[g]  = bus.mem_req;
        assign maddr_s[g] = bus.mem_addr;
        assign mgnt_s[g]  = bus.mem_gnt;
        assign rv_s[g]    = bus.mem_rvalid;

        icu_biu_refill #(.MAX_OUTST(g == 0 ? 2 : 1)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus)
        );

        // Memory returns the byte address of each word as its data, after lat[g] cycles.
        always @(posedge clk) begin
            if (!resetn) begin
                rq_data.delete();
                rq_due.delete();
                gap = 0;
                stall_seen <= 0;
                rv <= 1'b0;
                rd <= '0;
            end else begin
                if (bus.mem_req && bus.mem_gnt) begin
                    rq_data.push_back({bus.mem_addr, 2'b00});
                    rq_due.push_back(cyc + lat[g]);
                end
                if (bus.biu_icu_ack) stall_seen <= 0;
                else if (bus.mem_req && !bus.mem_gnt) stall_seen <= stall_seen + 1;
                if (gap > 0) begin
                    gap--;
                    rv <= 1'b0;
                end else if (rq_due.size() > 0 && rq_due[0] <= cyc + 1) begin
                    rv <= 1'b1;
                    rd <= rq_data.pop_front();
                    void'(rq_due.pop_front());
                    gap = gap_on[g] ? int'($urandom_range(4, 0)) : 0;
                end else begin
                    rv <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    function automatic void push_exp(input int g, input logic [28:0] a);
        logic [31:0] base;
        logic [64:0] e;
        base = {a[28:2], 5'b00000};
        for (int b = 0; b < 4; b++) begin
            e = {(b == 3), base + 32'(8 * b + 4), base + 32'(8 * b)};
            if (g == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
        end
    endfunction

    function automatic int exp_size(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic mon_beat(input int g);
        logic [64:0] e;
        checks++;
        if (exp_size(g) == 0) begin
            errors++;
            $display("FAIL beat_g%0d: got unexpected beat last=%0b data=%h, required no beat",
                     g, last_s[g], data_s[g]);
            return;
        end
        if (g == 0) e = exp_q0.pop_front();
        else e = exp_q1.pop_front();
        if ({last_s[g], data_s[g]} !== e) begin
            errors++;
            $display("FAIL beat_g%0d: got last=%0b data=%h, required last=%0b data=%h",
                     g, last_s[g], data_s[g], e[64], e[63:0]);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (dv_s[g]) mon_beat(g);
        end
    end

    // Watch one refill from the cycle its request is sampled (k=0) until the last beat.
    task automatic observe(input int g, input bit hold, input logic [28:0] next_a);
        int rvcnt = 0;
        int inflight = 0;
        bit prev_rv = 1'b0;
        ob_acks = 0; ob_ack_k = -1; ob_last_k = -1; ob_beats = 0;
        ob_pair_err = 0; ob_max_inf = 0; ob_addr0 = '0; ob_req0 = 1'b0;
        for (int i = 0; i < 4; i++) ob_bk[i] = -1;
        for (int k = 1; k <= 400 && ob_last_k < 0; k++) begin
            @(negedge clk);
            if (ack_s[g]) begin
                ob_acks++;
                if (ob_ack_k < 0) begin
                    ob_ack_k = k;
                    ob_addr0 = maddr_s[g];
                    ob_req0  = mreq_s[g];
                end
                if (hold) req_addr[g] = next_a;
                else req[g] = 1'b0;
            end
            if (mreq_s[g] && mgnt_s[g]) begin
                inflight++;
                if (inflight > ob_max_inf) ob_max_inf = inflight;
            end
            if (rv_s[g]) inflight--;
            if (dv_s[g]) begin
                if (ob_beats < 4) ob_bk[ob_beats] = k;
                ob_beats++;
                if (!prev_rv || rvcnt == 0 || (rvcnt % 2) != 0) ob_pair_err++;
                if (last_s[g]) ob_last_k = k;
            end
            if (rv_s[g]) rvcnt++;
            prev_rv = rv_s[g];
        end
        checks++;
        if (ob_last_k < 0) begin
            errors++;
            $display("FAIL g%0d timeout: got no last beat within 400 cycles, required one", g);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int limit;
        int se;
        limit = (v.g == 0) ? 2 : 1;
        lat[v.g] = v.lat;
        stall_on[v.g] = v.stall;
        gap_on[v.g] = v.gap;
        push_exp(v.g, v.addr);
        req_addr[v.g] = v.addr;
        req[v.g] = 1'b1;
        observe(v.g, 1'b0, '0);
        check({tag, ".ack_count"}, ob_acks, 1);
        check({tag, ".ack_cycle"}, ob_ack_k, 1);
        check({tag, ".first_addr"}, {ob_req0, ob_addr0}, {1'b1, v.addr[28:2], 3'b000});
        check({tag, ".beats"}, ob_beats, 4);
        check({tag, ".pairing"}, ob_pair_err, 0);
        check({tag, ".inflight_ok"}, ob_max_inf <= limit, 1);
        if (v.first_k >= 0) check({tag, ".first_beat"}, ob_bk[0], v.first_k);
        if (v.last_k >= 0) check({tag, ".last_cycle"}, ob_last_k, v.last_k);
        if (v.spacing > 0) begin
            se = 0;
            for (int i = 1; i < 4; i++) if (ob_bk[i] - ob_bk[i - 1] != v.spacing) se++;
            check({tag, ".spacing"}, se, 0);
        end
        repeat (2) @(negedge clk);
        check({tag, ".sb_drained"}, exp_size(v.g), 0);
        if (v.g == 0) exp_q0.delete();
        else exp_q1.delete();
    endtask

    initial begin
        int nb;
        int cnt;
        vec_t post;
        //            g  addr           lat stl gap first last spacing
        vecs[0] = '{0, 29'h0002021, 1, 1'b0, 1'b0, 4, 10, 2};
        vecs[1] = '{0, 29'h0002021, 1, 1'b1, 1'b0, 4, 13, 0};
        vecs[2] = '{0, 29'h1FFFFFFF, 1, 1'b0, 1'b0, 4, 10, 2};
        vecs[3] = '{0, 29'h0000007, 2, 1'b0, 1'b0, -1, -1, 0};
        vecs[4] = '{0, 29'h0ABCDE5, 1, 1'b0, 1'b1, -1, -1, 0};
        vecs[5] = '{0, 29'h1234567, 3, 1'b0, 1'b1, -1, -1, 0};
        vecs[6] = '{1, 29'h0002021, 3, 1'b0, 1'b0, 9, 33, 8};
        vecs[7] = '{1, 29'h0555555, 1, 1'b0, 1'b0, 5, 17, 4};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset_outputs_g%0d", g),
                  {ack_s[g], dv_s[g], last_s[g], mreq_s[g], data_s[g], maddr_s[g]}, '0);
        end
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back: request held high through the first last beat with a new address.
        lat[0] = 1; stall_on[0] = 1'b0; gap_on[0] = 1'b0;
        push_exp(0, 29'h0002021);
        push_exp(0, 29'h0002400);
        req_addr[0] = 29'h0002021;
        req[0] = 1'b1;
        observe(0, 1'b1, 29'h0002400);
        check("b2b.first_last", ob_last_k, 10);
        observe(0, 1'b0, '0);
        check("b2b.ack_after_last", ob_ack_k, 2);
        check("b2b.first_addr", {ob_req0, ob_addr0}, {1'b1, 30'h4800});
        check("b2b.second_last", ob_last_k, 11);
        check("b2b.beats", ob_beats, 4);
        repeat (2) @(negedge clk);
        check("b2b.sb_drained", exp_size(0), 0);
        exp_q0.delete();

        // Reset right after the second beat abandons the line.
        push_exp(0, 29'h0333333);
        req_addr[0] = 29'h0333333;
        req[0] = 1'b1;
        nb = 0;
        for (int k = 1; k <= 50 && nb < 2; k++) begin
            @(negedge clk);
            if (ack_s[0]) req[0] = 1'b0;
            if (dv_s[0]) nb++;
        end
        check("rst.beats_before", nb, 2);
        resetn = 1'b0;
        @(negedge clk);
        check("rst.outputs", {ack_s[0], dv_s[0], last_s[0], mreq_s[0], data_s[0], maddr_s[0]}, '0);
        exp_q0.delete();
        resetn = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (dv_s[0] || mreq_s[0] || ack_s[0]) cnt++;
        end
        check("rst.quiet", cnt, 0);
        post = '{0, 29'h0F0F0F3, 1, 1'b0, 1'b0, 4, 10, 2};
        run_vec(post, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icu_biu_refill.md
# icu_biu_refill

Bus-interface refill engine sitting directly downstream of the instruction cache (ICU) on its miss path. It accepts a single cache-line refill request from the ICU and fetches the 32-byte line from a 32-bit, pipelined, in-order memory read port. Pairs of 32-bit words are packed into 64-bit beats, and four beats are returned to the ICU with valid/last strobes. It is the producer of `biu_icu_ack`, `biu_icu_data_valid`, `biu_icu_data` and `biu_icu_data_last`.

## Interface
- `MAX_OUTST`, default 2: maximum memory reads issued but not yet returned. Legal range 1..4.
- `clk` in 1: single clock, all logic on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `icu_biu_req` in 1: refill request. Level signal, held by the ICU until it sees `biu_icu_ack`.
- `icu_biu_addr` in [31:3]: miss address. Only [31:5] (the line) is used.
- `biu_icu_ack` out 1: one-cycle pulse that accepts the request.
- `biu_icu_data_valid` out 1: beat valid, one cycle per beat.
- `biu_icu_data` out 64: beat data. Word at the lower address goes in [31:0].
- `biu_icu_data_last` out 1: asserted with the 4th beat only.
- `mem_req` out 1: word read request.
- `mem_addr` out [31:2]: word address.
- `mem_gnt` in 1: the request is accepted in any cycle where `mem_req & mem_gnt`.
- `mem_rvalid` in 1: read data valid. Responses are in order, earliest 1 cycle after the grant.
- `mem_rdata` in 32: read data.

## Operation
- States: IDLE, FETCH.
- **IDLE:**
  - `icu_biu_req` sampled high: latch `line <= icu_biu_addr[31:5]`, clear the counters, go to FETCH.
  - `biu_icu_ack` is registered and is 1 in the first FETCH cycle only.
- **FETCH:** `icu_biu_req` is ignored.
- **Issue counter** `iss` (0..8):
  - `mem_req = (state==FETCH) & (iss<8) & (outst<MAX_OUTST)`.
  - `mem_addr = {line, iss[2:0]}`.
  - `iss` increments on `mem_req & mem_gnt`.
  - While `mem_req` is high and ungranted, `mem_addr` stays stable.
- **Outstanding counter** `outst`: +1 on grant, -1 on `mem_rvalid`, both in the same cycle gives net 0. The limit compares the registered `outst` only.
- **Response counter** `rsp` (0..7), +1 per `mem_rvalid`:
  - Even `rsp`: store `mem_rdata` into the low half-register.
  - Odd `rsp`: register the output beat as `biu_icu_data <= {mem_rdata, low}` and `biu_icu_data_valid <= 1` for one cycle.
  - `rsp==7`: also set `biu_icu_data_last <= 1` and go to IDLE.
- **Beat order:** beats always go 0,1,2,3 from the line base. There is no critical-word-first.
- **Ignored inputs:** `mem_rvalid` in IDLE is ignored (protocol error, not counted).
- **Output holding:** `biu_icu_data` holds its last value between beats. Only the valid strobe qualifies it.
- **Reset:**
  - All outputs are 0 and the state is IDLE, with all counters 0.
  - A reset mid-refill abandons the line. The memory must be reset with the same `resetn`, so that stale responses never arrive.
  - Reset takes priority over every other event in that cycle.

## Timing
- Request sampled in IDLE at cycle T: `biu_icu_ack` and the first `mem_req` are both at T+1.
- Zero-wait memory (`mem_gnt`=1, `mem_rvalid` 1 cycle after grant), `MAX_OUTST`>=2:
  - Grants at T+1..T+8, rvalid at T+2..T+9.
  - Beats at T+4, T+6, T+8, T+10. Last at T+10.
- Beat latency is 1 cycle after the odd-word rvalid.
- Back in IDLE at T+11. The next request sampled at T+11 is acked at T+12.
- Throughput is 1 word per cycle when `MAX_OUTST` covers the memory latency. Otherwise it is bounded by `MAX_OUTST`/latency.
- With `MAX_OUTST`=1, the next `mem_req` rises the cycle after `mem_rvalid`.

## Test plan
- **Basic refill**, zero-wait memory returning `rdata={mem_addr,2'b00}`, req with `addr='h2021` at T:
  - Ack at T+1 only.
  - `mem_addr` 'h4040..'h4047.
  - Beats `{0x00010104,0x00010100}`, `{0x0001010C,0x00010108}`, `{0x00010114,0x00010110}`, `{0x0001011C,0x00010118}` at T+4/6/8/10.
  - Last at T+10 only.
- **Grant stall:** `mem_gnt` low for 3 cycles on word 2 -> `mem_req` stays high with `mem_addr` 'h4042 stable, no extra grant counted, all 4 beats correct, last delayed by 3 cycles.
- **Outstanding limit:** `MAX_OUTST`=1, rvalid latency 3 -> never more than 1 read in flight, beats 8 cycles apart, data correct.
- **Back-to-back:** ICU holds req high through last, second `addr='h2400` -> second ack exactly 2 cycles after the first last, second line 'h4800..'h4807 fetched.
- **Reset mid-refill:** `resetn` low 1 cycle right after beat 1 -> the next cycle has all outputs 0, no further beats or `mem_req`. A new request then yields a clean 4-beat refill.
- **Gapped responses:** `mem_rvalid` with random 0–4 cycle gaps -> beat count is exactly 4, data order is preserved, `biu_icu_data_valid` is never asserted between the words of a pair.
